// File: rtl/seq_multiplier_pkg.sv
// -----------------------------------------------------------------------------
// seq_multiplier_pkg
//   Shared definitions for the sequential shift-add multiplier.
//   Contents:
//     STATE_W  - width of the controller state encoding
//     state_t  - controller states IDLE / CALC / DONE
// -----------------------------------------------------------------------------
package seq_multiplier_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : seq_multiplier_pkg

// File: rtl/seq_multiplier_step.sv
// -----------------------------------------------------------------------------
// seq_multiplier_step
//   One combinational shift-add step of the multiplier datapath.
//   If the current multiplier LSB (i_acc_lo[0]) is set, the multiplicand is
//   added into the upper accumulator half; the (WIDTH+1)-bit sum, including
//   its carry, is then shifted right by one together with the lower half.
//   Ports:
//     i_acc_hi  [WIDTH-1:0]  upper accumulator half (partial product)
//     i_acc_lo  [WIDTH-1:0]  lower accumulator half (remaining multiplier bits)
//     i_mcand   [WIDTH-1:0]  multiplicand
//     o_acc_hi  [WIDTH-1:0]  next upper half
//     o_acc_lo  [WIDTH-1:0]  next lower half
// -----------------------------------------------------------------------------
module seq_multiplier_step
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_acc_hi,
    input  logic [WIDTH-1:0] i_acc_lo,
    input  logic [WIDTH-1:0] i_mcand,
    output logic [WIDTH-1:0] o_acc_hi,
    output logic [WIDTH-1:0] o_acc_lo
);

    logic [WIDTH:0] w_sum;

    always_comb begin
        w_sum = {1'b0, i_acc_hi};
        if (i_acc_lo[0]) begin
            w_sum = {1'b0, i_acc_hi} + {1'b0, i_mcand};
        end
        // {carry, acc_hi, acc_lo} >> 1
        o_acc_hi = w_sum[WIDTH:1];
        o_acc_lo = {w_sum[0], i_acc_lo[WIDTH-1:1]};
    end

endmodule : seq_multiplier_step

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Sequential shift-add multiplier, one partial-product step per clock.
//   Operands are accepted with a valid/ready handshake in IDLE, WIDTH steps
//   are performed in CALC, and the product is offered in DONE until the
//   consumer accepts it. out_valid rises exactly WIDTH cycles after the
//   accepting edge; with out_ready held high a new operand pair can be
//   accepted every WIDTH+2 cycles.
//
//   Build option:
//     SEQ_MULTIPLIER_SIGNED_EN - when defined, a, b and product are two's
//       complement. Magnitudes are multiplied and the result is negated on
//       the DONE-entry edge when the operand signs differ. When undefined,
//       the block is unsigned only and carries no sign logic.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   synchronous, active-high reset
//     in_valid   in   operands a/b valid
//     in_ready   out  block can accept operands (IDLE only)
//     a          in   [WIDTH-1:0]   multiplicand
//     b          in   [WIDTH-1:0]   multiplier
//     out_valid  out  product valid (DONE only)
//     out_ready  in   consumer accepts product
//     product    out  [2*WIDTH-1:0] a*b, held until the output handshake
//     busy       out  high whenever the controller is not in IDLE
// -----------------------------------------------------------------------------
module seq_multiplier
    import seq_multiplier_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [WIDTH-1:0]     r_mcand;
    logic [WIDTH-1:0]     r_acc_hi;
    logic [WIDTH-1:0]     r_acc_lo;
    logic [2*WIDTH-1:0]   r_product;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 r_busy;

    logic [WIDTH-1:0]     w_acc_hi_next;
    logic [WIDTH-1:0]     w_acc_lo_next;
    logic [2*WIDTH-1:0]   w_final;
    logic [2*WIDTH-1:0]   w_result;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic                 w_accept;

    seq_multiplier_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_acc_hi (r_acc_hi),
        .i_acc_lo (r_acc_lo),
        .i_mcand  (r_mcand),
        .o_acc_hi (w_acc_hi_next),
        .o_acc_lo (w_acc_lo_next)
    );

    // Value the accumulator takes after the step on the current edge.
    assign w_final  = {w_acc_hi_next, w_acc_lo_next};
    assign w_accept = in_valid && r_in_ready;

`ifdef SEQ_MULTIPLIER_SIGNED_EN
    logic r_sign;

    // The most-negative operand negates to itself, which read unsigned is
    // exactly its magnitude 2^(WIDTH-1).
    assign w_a_mag  = a[WIDTH-1] ? -a : a;
    assign w_b_mag  = b[WIDTH-1] ? -b : b;
    assign w_result = r_sign ? -w_final : w_final;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (r_state == IDLE && w_accept) begin
            r_sign <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end
`else
    assign w_a_mag  = a;
    assign w_b_mag  = b;
    assign w_result = w_final;
`endif

    // Controller, counter and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mcand     <= '0;
            r_acc_hi    <= '0;
            r_acc_lo    <= '0;
            r_product   <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mcand    <= w_a_mag;
                        r_acc_hi   <= '0;
                        r_acc_lo   <= w_b_mag;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= CALC;
                    end
                end

                CALC: begin
                    r_acc_hi <= w_acc_hi_next;
                    r_acc_lo <= w_acc_lo_next;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    // r_cnt counts completed steps; the step taken while it
                    // reads WIDTH-1 is the last one, so its result is loaded
                    // straight into product on this same edge.
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        r_product   <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= IDLE;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;

endmodule : seq_multiplier

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8. Drivers push
//   the hand-computed product and the accept cycle into a queue; monitors pop
//   and compare whenever the DUT presents out_valid. Build with
//   SEQ_MULTIPLIER_SIGNED_EN defined to run the two's complement vectors.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0] a4, b4;
    logic [7:0] product4;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    seq_multiplier #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .product   (product4),
        .busy      (busy4)
    );

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .product   (product8),
        .busy      (busy8)
    );

    typedef struct {
        logic [15:0] prod;
        int          acc_cyc;
    } exp_t;

    exp_t q4[$];
    exp_t q8[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitors ----------------
    logic prev_ov4 = 1'b0;
    always @(negedge clk) begin
        if (out_valid4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid4: got product 0x%0h, expected no result", product4);
            end else begin
                if (!prev_ov4) check("latency4", 16'(cyc - q4[0].acc_cyc), 16'd4);
                check("product4", {8'h00, product4}, q4[0].prod);
                if (out_ready4) void'(q4.pop_front());
            end
        end
        prev_ov4 = out_valid4;
    end

    logic prev_ov8 = 1'b0;
    always @(negedge clk) begin
        if (out_valid8) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out_valid8: got product 0x%0h, expected no result", product8);
            end else begin
                if (!prev_ov8) check("latency8", 16'(cyc - q8[0].acc_cyc), 16'd8);
                check("product8", product8, q8[0].prod);
                if (out_ready8) void'(q8.pop_front());
            end
        end
        prev_ov8 = out_valid8;
    end

    // ---------------- drivers ----------------
    task automatic send4(input logic [3:0] a, input logic [3:0] b, input logic [15:0] exp,
                         output int acc);
        exp_t e;
        a4 = a; b4 = b; in_valid4 = 1'b1; acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready4 && !rst) begin
                acc = cyc + 1;
                e.prod = exp; e.acc_cyc = acc;
                q4.push_back(e);
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL send4_timeout: got no accept, expected accept of a=%0h b=%0h", a, b);
        end
        @(posedge clk); #1;
        in_valid4 = 1'b0;
        if (acc >= 0) begin
            check("in_ready4_busy", {15'd0, in_ready4}, 16'd0);
            check("busy4_busy", {15'd0, busy4}, 16'd1);
        end
    endtask

    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        exp_t e;
        int   acc;
        a8 = a; b8 = b; in_valid8 = 1'b1; acc = -1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready8 && !rst) begin
                acc = cyc + 1;
                e.prod = exp; e.acc_cyc = acc;
                q8.push_back(e);
                break;
            end
        end
        if (acc < 0) begin
            checks++; errors++;
            $display("FAIL send8_timeout: got no accept, expected accept of a=%0h b=%0h", a, b);
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait_idle;
        bit done = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (q4.size() == 0 && q8.size() == 0 && !busy4 && !busy8) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: got %0d/%0d pending results, expected 0", q4.size(), q8.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset4(input string tag);
        check({tag, "_in_ready"},  {15'd0, in_ready4},  16'd1);
        check({tag, "_out_valid"}, {15'd0, out_valid4}, 16'd0);
        check({tag, "_busy"},      {15'd0, busy4},      16'd0);
        check({tag, "_product"},   {8'h00, product4},   16'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc0, acc1, acc2, t_rise;
        bit seen;

        rst = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; out_ready4 = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset4("reset4");
        check("reset8_product", product8, 16'd0);
        check("reset8_in_ready", {15'd0, in_ready8}, 16'd1);
        rst = 1'b0;
        @(posedge clk); #1;

`ifndef SEQ_MULTIPLIER_SIGNED_EN
        // Back-to-back stream with out_ready high.
        send4(4'd9,  4'd1, 16'd9,   acc0);
        send4(4'd10, 4'd5, 16'd50,  acc1);
        check("throughput4", 16'(acc1 - acc0), 16'd6);
        send4(4'd12, 4'd5, 16'd60,  acc2);
        // Operands wiggle with in_valid high during CALC: must be ignored.
        a4 = 4'd1; b4 = 4'd1; in_valid4 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        wait_idle();
        send4(4'd15, 4'd15, 16'd225, acc0);
        send4(4'd0,  4'd15, 16'd0,   acc0);
        send4(4'd15, 4'd0,  16'd0,   acc0);
        wait_idle();

        // Backpressure: product must hold while out_ready is low.
        out_ready4 = 1'b0;
        send4(4'd12, 4'd9, 16'd108, acc0);
        seen = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid4) begin seen = 1'b1; break; end
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL bp_wait: got out_valid4=0, expected 1");
        end
        @(posedge clk); #1;
        a4 = 4'd3; b4 = 4'd3; in_valid4 = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", {15'd0, out_valid4}, 16'd1);
            check("bp_in_ready",  {15'd0, in_ready4},  16'd0);
            check("bp_product",   {8'h00, product4},   16'd108);
        end
        @(posedge clk); #1;
        out_ready4 = 1'b1;
        t_rise = cyc;
        send4(4'd3, 4'd3, 16'd9, acc1);
        check("bp_accept_delay", 16'(acc1 - t_rise), 16'd2);
        wait_idle();

        // Reset during CALC discards the in-flight result.
        send4(4'd15, 4'd15, 16'd225, acc0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q4.delete();
        check_reset4("midreset4");
        repeat (8) @(posedge clk);
        #1;
        send4(4'd7, 4'd6, 16'd42, acc0);
        wait_idle();

        // Reset and in_valid in the same cycle: reset wins.
        a4 = 4'd5; b4 = 4'd5; in_valid4 = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid4 = 1'b0;
        check_reset4("rst_vs_valid4");
        repeat (6) @(posedge clk);
        #1;

        send8(8'd255, 8'd255, 16'd65025);
        send8(8'd200, 8'd3,   16'd600);
        send8(8'd0,   8'd77,  16'd0);
        wait_idle();
`else
        send4(4'h8, 4'h8, 16'h0040, acc0);
        send4(4'hD, 4'h5, 16'h00F1, acc0);
        send4(4'h7, 4'hF, 16'h00F9, acc0);
        send4(4'h8, 4'h7, 16'h00C8, acc0);
        send4(4'h0, 4'hB, 16'h0000, acc0);
        send4(4'hF, 4'hF, 16'h0001, acc0);
        wait_idle();
        send4(4'hF, 4'hF, 16'h0001, acc0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        q4.delete();
        check_reset4("midreset4");
        repeat (8) @(posedge clk);
        #1;
        send8(8'hFF, 8'hFF, 16'h0001);
        send8(8'hC8, 8'h03, 16'hFF58);
        send8(8'h80, 8'h80, 16'h4000);
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_seq_multiplier

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add unsigned multiplier. It is the next generation of the team's 4-bit combinational multiplier. It trades area for latency: one partial-product step per clock. Operand and result transfers use valid/ready handshakes, so it drops into streaming datapaths and can absorb backpressure.

Parameters:
WIDTH, 4, operand width in bits (>= 2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), step counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands a/b valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
out_valid  output  1  product valid
out_ready  input  1  consumer accepts product
product  output  2*WIDTH  result a*b
busy  output  1  high whenever state != IDLE

Behaviour:
- Clocking and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, counter=0, internal accumulator=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On the edge where in_valid&&in_ready: latch mcand=a and {acc_hi=0, acc_lo=b}, clear counter, go to CALC.
- CALC:
  - in_ready=0.
  - Each edge: if acc_lo[0]=1, sum = acc_hi + mcand (WIDTH+1 bits incl. carry); else sum = acc_hi.
  - Then {carry,acc_hi,acc_lo} shifts right by 1, i.e. {acc_hi,acc_lo} <= {sum, acc_lo[WIDTH-1:1]}. Counter increments.
  - When the counter reaches WIDTH-1 on this edge: go to DONE and load product with the final shifted value on the same edge.
- DONE:
  - out_valid=1; product held stable until the handshake.
  - On out_valid&&out_ready: go to IDLE, out_valid deasserts next cycle.
  - in_ready stays 0 in DONE, so there is no same-cycle accept/deliver overlap.
- Latency: out_valid is high exactly WIDTH cycles after the accepting edge. Throughput is one result per WIDTH+2 cycles with out_ready held high.
- Width rule: product = a*b exactly, never truncated. The maximum (2^WIDTH-1)^2 fits 2*WIDTH bits.
- Boundaries:
  - a=0 or b=0 -> product=0 with the same latency (no early exit).
  - in_valid high while busy is ignored; operands are not sampled.
  - a/b changing during CALC has no effect.
  - out_ready low holds DONE indefinitely with product stable.
  - rst asserted in any state returns to reset values on the next edge. An in-flight result is discarded and out_valid is never asserted for it.
  - rst and in_valid high in the same cycle: reset wins, no accept.

Optional Feature:
- Macro: SEQ_MULTIPLIER_SIGNED_EN.
- Defined: a, b and product are two's complement.
  - On accept, latch the magnitudes |a| and |b| plus sign = a[MSB]^b[MSB].
  - On the DONE-entry edge, product is loaded with the negated result if sign=1.
  - Latency is unchanged. The most-negative operand is handled: its magnitude 2^(WIDTH-1) fits WIDTH bits unsigned.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Package seq_multiplier_pkg holds:
  - state enum {IDLE, CALC, DONE} as 2-bit localparams;
  - STATE_W=2.
- Sub-module seq_multiplier_step: the combinational add-and-shift datapath.
  - Inputs: acc_hi, acc_lo, mcand.
  - Outputs: next acc_hi, next acc_lo.
  - The top holds the FSM, counter and registers.

Test Plan:
- WIDTH=4, out_ready=1. Send (9,1),(10,5),(12,5),(12,9),(15,15) -> products 9, 50, 60, 108, 225. Each out_valid appears exactly 4 cycles after its accept; in_ready is low while busy.
- WIDTH=4, a=0,b=15 then a=15,b=0 -> product=0 both times, same 4-cycle latency.
- Backpressure: out_ready=0 for 10 cycles after out_valid for 12*9 -> product holds 108 and out_valid stays 1. The next in_valid (3,3) is not accepted until one cycle after out_ready rises. It then yields 9.
- Reset mid-op: accept (15,15), assert rst for 1 cycle at step 2 -> out_valid never asserts for that transaction. All outputs equal reset values; a following (7,6) returns 42.
- WIDTH=8: (255,255) -> 65025 after 8 cycles; (200,3) -> 600.
- SEQ_MULTIPLIER_SIGNED_EN defined, WIDTH=4:
  - (-8,-8) -> 64; (-3,5) -> -15 (8'hF1); (7,-1) -> -7 (8'hF9).
  - Latency is still 4 cycles.
